instruction_fetch_controller: RTL and testbench

Sequences instruction fetches from the synchronous instruction memory (one-cycle read latency) and hands instructions to decode over a valid/ready handshake. It holds the PC, keeps a 2-entry instruction buffer, and kills in-flight reads on a branch/jump redirect. It also yields the memory while the program loader owns it (`halt`). It sits between the instruction memory and the decode stage of the RV32I core.

---
 rtl/instruction_fetch_controller_pkg.sv | 21 ++
 rtl/instruction_fetch_controller_fetch_buffer.sv | 70 +++++++
 rtl/instruction_fetch_controller.sv | 100 ++++++++++
 tb/tb_instruction_fetch_controller.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_controller_pkg.sv
// Shared definitions for the instruction fetch controller: state encoding,
// datapath widths and the sequential-PC helper.
package instruction_fetch_controller_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;
  localparam int BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_HOLD  = 2'd2,
    ST_FAULT = 2'd3
  } fetch_state_e;

  // Wraps naturally at 2^32, so FFFF_FFFC steps to 0000_0000.
  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

endpackage

// File: rtl/instruction_fetch_controller_fetch_buffer.sv
// Two-entry {instr, pc} FIFO between the memory response and decode.
// Head is held in dedicated registers so the decode-facing outputs are registered.
module fetch_buffer
  import instruction_fetch_controller_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            push,
  input  logic [XLEN-1:0] push_instr,
  input  logic [XLEN-1:0] push_pc,
  input  logic            pop,
  output logic [1:0]      occupancy,
  output logic            head_valid,
  output logic [XLEN-1:0] head_instr,
  output logic [XLEN-1:0] head_pc
);

  logic [1:0]      count;
  logic [XLEN-1:0] tail_instr;
  logic [XLEN-1:0] tail_pc;
  logic            do_pop;

  assign do_pop     = pop & (count != 2'd0);
  assign occupancy  = count;
  assign head_valid = (count != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_instr <= '0;
      head_pc    <= '0;
      tail_instr <= '0;
      tail_pc    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      unique case ({push, do_pop})
        2'b11: begin
          if (count == 2'd1) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            head_instr <= tail_instr;
            head_pc    <= tail_pc;
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
        end
        2'b01: begin
          head_instr <= tail_instr;
          head_pc    <= tail_pc;
          count      <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            head_instr <= push_instr;
            head_pc    <= push_pc;
          end else begin
            tail_instr <= push_instr;
            tail_pc    <= push_pc;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: PC, credit-based issue to a one-cycle-latency
// instruction memory, redirect kill/flush, loader hold and misaligned-target fault.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            fetch_valid,
  output logic [XLEN-1:0] fetch_instr,
  output logic [XLEN-1:0] fetch_pc,
  input  logic            fetch_ready,
  output logic            misalign_err
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q;
  logic            inflight_p1;
  logic [XLEN-1:0] issued_pc_p1;
  logic            misalign_q;

  logic            redirect_ok;
  logic            redirect_bad;
  logic            pop;
  logic            push;
  logic            issue;
  logic            credit_ok;
  logic [1:0]      occupancy;

  assign redirect_ok  = redirect_valid & (redirect_pc[1:0] == 2'b00);
  assign redirect_bad = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign pop          = fetch_valid & fetch_ready;

  // Reads already issued count against buffer space so a response never overflows.
  assign credit_ok = ({1'b0, occupancy} + {2'b00, inflight_p1}) < (3'd2 + {2'b00, pop});
  assign issue     = (state_q == ST_RUN) & ~halt & ~redirect_valid & credit_ok;

  // Any redirect kills the response arriving this cycle.
  assign push = inflight_p1 & ~redirect_valid;

  assign imem_en      = issue;
  assign imem_addr    = pc_q;
  assign misalign_err = misalign_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  if (halt)  state_d = ST_HOLD;
      ST_HOLD: if (!halt) state_d = ST_RUN;
      default: state_d = ST_FAULT;
    endcase
    if (redirect_bad) state_d = ST_FAULT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pc_q        <= RESET_PC;
      inflight_p1 <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      inflight_p1 <= issue;
      misalign_q  <= misalign_q | redirect_bad;
      if (redirect_ok && state_q != ST_FAULT) begin
        pc_q <= redirect_pc;
      end else if (issue) begin
        pc_q <= next_pc(pc_q);
      end
    end
  end

  // ---- memory access stage -> response stage ----
  always_ff @(posedge clk) begin
    if (issue) issued_pc_p1 <= pc_q;
  end

  fetch_buffer u_buffer (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (redirect_valid),
    .push       (push),
    .push_instr (imem_rdata),
    .push_pc    (issued_pc_p1),
    .pop        (pop),
    .occupancy  (occupancy),
    .head_valid (fetch_valid),
    .head_instr (fetch_instr),
    .head_pc    (fetch_pc)
  );

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Directed bench for instruction_fetch_controller with a one-cycle memory
// whose word k holds the value k.
module tb_instruction_fetch_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        halt;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_en;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic        fetch_ready;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  instruction_fetch_controller #(.RESET_PC(32'h0000_0100)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_en        (imem_en),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .fetch_valid    (fetch_valid),
    .fetch_instr    (fetch_instr),
    .fetch_pc       (fetch_pc),
    .fetch_ready    (fetch_ready),
    .misalign_err   (misalign_err)
  );

  always @(posedge clk) begin
    if (imem_en) imem_rdata <= imem_addr >> 2;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic en, input logic [31:0] addr,
                      input logic fv, input logic [31:0] fpc);
    #1;
    check_val({tag, ".imem_en"}, 32'(imem_en), 32'(en));
    if (en) check_val({tag, ".imem_addr"}, imem_addr, addr);
    check_val({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(fv));
    if (fv) begin
      check_val({tag, ".fetch_pc"}, fetch_pc, fpc);
      check_val({tag, ".fetch_instr"}, fetch_instr, fpc >> 2);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, ".imem_en"}, 32'(imem_en), 32'd0);
    check_val({tag, ".imem_addr"}, imem_addr, 32'h0000_0100);
    check_val({tag, ".fetch_valid"}, 32'(fetch_valid), 32'd0);
    check_val({tag, ".fetch_pc"}, fetch_pc, 32'd0);
    check_val({tag, ".fetch_instr"}, fetch_instr, 32'd0);
    check_val({tag, ".misalign_err"}, 32'(misalign_err), 32'd0);
  endtask

  initial begin
    rst_n          = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b1;

    repeat (2) next_cycle();
    #1;
    check_reset_outputs("rst");

    // cycle 0 after release is IDLE
    next_cycle();
    rst_n = 1'b1;
    look("c0", 1'b0, 32'h0, 1'b0, 32'h0);

    for (int c = 1; c <= 9; c++) begin
      next_cycle();
      look($sformatf("stream%0d", c), 1'b1, 32'h100 + 32'(4 * (c - 1)),
           c >= 3, 32'h100 + 32'(4 * (c - 3)));
    end

    for (int c = 10; c <= 14; c++) begin
      next_cycle();
      fetch_ready = 1'b0;
      look($sformatf("stall%0d", c), 1'b0, 32'h0, 1'b1, 32'h11C);
    end

    for (int c = 15; c <= 18; c++) begin
      next_cycle();
      fetch_ready = 1'b1;
      look($sformatf("drain%0d", c), 1'b1, 32'h124 + 32'(4 * (c - 15)),
           1'b1, 32'h11C + 32'(4 * (c - 15)));
    end

    next_cycle(); fetch_ready = 1'b0; look("c19", 1'b0, 32'h0, 1'b1, 32'h12C);
    next_cycle(); fetch_ready = 1'b1; look("c20", 1'b1, 32'h134, 1'b1, 32'h12C);

    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    look("redir", 1'b0, 32'h0, 1'b1, 32'h130);
    next_cycle(); redirect_valid = 1'b0; look("redir+1", 1'b1, 32'h200, 1'b0, 32'h0);
    next_cycle(); look("redir+2", 1'b1, 32'h204, 1'b0, 32'h0);
    next_cycle(); look("redir+3", 1'b1, 32'h208, 1'b1, 32'h200);
    next_cycle(); look("redir+4", 1'b1, 32'h20C, 1'b1, 32'h204);

    next_cycle(); halt = 1'b1; look("halt0", 1'b0, 32'h0, 1'b1, 32'h208);
    next_cycle(); look("halt1", 1'b0, 32'h0, 1'b1, 32'h20C);
    next_cycle(); look("halt2", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle(); look("halt3", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle(); halt = 1'b0; look("unhalt0", 1'b0, 32'h0, 1'b0, 32'h0);
    next_cycle(); look("unhalt1", 1'b1, 32'h210, 1'b0, 32'h0);
    next_cycle(); look("unhalt2", 1'b1, 32'h214, 1'b0, 32'h0);
    next_cycle(); look("unhalt3", 1'b1, 32'h218, 1'b1, 32'h210);

    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    look("wrapredir", 1'b0, 32'h0, 1'b1, 32'h214);
    next_cycle(); redirect_valid = 1'b0; look("wrap1", 1'b1, 32'hFFFF_FFF8, 1'b0, 32'h0);
    next_cycle(); look("wrap2", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    next_cycle(); look("wrap3", 1'b1, 32'h0000_0000, 1'b1, 32'hFFFF_FFF8);
    next_cycle(); look("wrap4", 1'b1, 32'h0000_0004, 1'b1, 32'hFFFF_FFFC);
    next_cycle(); look("wrap5", 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000);

    next_cycle();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h202;
    look("misredir", 1'b0, 32'h0, 1'b1, 32'h4);
    check_val("misredir.err", 32'(misalign_err), 32'd0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      redirect_valid = 1'b0;
      look($sformatf("fault%0d", c), 1'b0, 32'h0, 1'b0, 32'h0);
      check_val($sformatf("fault%0d.err", c), 32'(misalign_err), 32'd1);
    end

    next_cycle();
    rst_n = 1'b0;
    #1;
    check_val("faultrst.err", 32'(misalign_err), 32'd0);
    next_cycle();
    rst_n = 1'b1;
    look("re0", 1'b0, 32'h0, 1'b0, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      look($sformatf("re%0d", c), 1'b1, 32'h100 + 32'(4 * (c - 1)),
           c >= 3, 32'h100 + 32'(4 * (c - 3)));
    end

    // drop reset between clock edges
    rst_n = 1'b0;
    #1;
    check_reset_outputs("asyncrst");
    next_cycle();
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
